// File: rtl/uart_pkg.sv
// Shared UART types and constants: TX state encoding, frame bit levels, default widths.
package uart_pkg;

  localparam int   UART_DATA_W    = 8;
  localparam int   UART_DIV_W     = 16;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // odd = 0 gives even parity: the bit that makes the total count of ones even.
  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side handshake between the TX FIFO (slave) and the serializer that pops it (master).
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                   fifo_empty_i;
  logic [UART_DATA_W-1:0] fifo_data_i;
  logic                   fifo_rd_o;

  modport master (input fifo_empty_i, input fifo_data_i, output fifo_rd_o);
  modport slave  (output fifo_empty_i, output fifo_data_i, input fifo_rd_o);

endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..div-1 while enabled and ticks on the last count of each bit.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  // A divisor of 0 or 1 ticks every enabled clock, so the counter can never run away.
  assign w_last = (div_i <= DIV_W'(1)) || (r_cnt == div_i - DIV_W'(1));
  assign tick_o = en_i && w_last;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i || tick_o) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: pops bytes from the TX FIFO and drives start/8 data/stop frames on tx_o.
// Define UART_TX_PARITY_EN to insert a parity bit (odd/even from parity_odd_i) after the data bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_en_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic                 parity_odd_i,
  uart_tx_serializer_if.master fifo_if,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 tx_done_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_bit_cnt;
  logic              r_parity;
  logic              r_tx;
  logic              w_tick;
  logic              w_baud_clr;
  logic              w_baud_en;
  logic              w_tx_next;
  logic              w_can_start;

  assign w_can_start = tx_en_i && !fifo_if.fifo_empty_i;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_baud_clr),
    .en_i   (w_baud_en),
    .div_i  (r_div),
    .tick_o (w_tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    w_state_next = r_state;
    unique case (r_state)
      IDLE:   if (w_can_start) w_state_next = FETCH;
      FETCH:  w_state_next = LOAD;
      LOAD:   w_state_next = START;
      START:  if (w_tick) w_state_next = DATA;
      DATA: begin
        if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
      PARITY: if (w_tick) w_state_next = STOP;
      STOP:   if (w_tick) w_state_next = w_can_start ? FETCH : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_if.fifo_rd_o = (r_state == FETCH);
    busy_o            = (r_state != IDLE);
    tx_done_o         = (r_state == STOP) && w_tick;
    w_baud_clr        = (r_state == LOAD);
    w_baud_en         = (r_state == START) || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);
    // tx is registered, so it is computed from the state being entered.
    w_tx_next = UART_STOP_BIT;
    case (w_state_next)
      START:   w_tx_next = UART_START_BIT;
      DATA:    w_tx_next = ((r_state == DATA) && w_tick) ? r_shift[1] : r_shift[0];
      PARITY:  w_tx_next = r_parity;
      default: w_tx_next = UART_STOP_BIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_shift   <= '0;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (r_state == LOAD) begin
      r_shift   <= fifo_if.fifo_data_i;
      r_div     <= (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
      r_bit_cnt <= '0;
      r_parity  <= parity_bit(fifo_if.fifo_data_i, parity_odd_i);
    end else if ((r_state == DATA) && w_tick) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tx <= UART_STOP_BIT;
    end else begin
      r_tx <= w_tx_next;
    end
  end

  assign tx_o = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: behavioural FIFO, frame reference model and line monitor.
module tb_uart_tx_serializer;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       odd;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tx_en_i;
  logic [15:0] baud_div_i;
  logic        parity_odd_i;
  logic        tx_o;
  logic        busy_o;
  logic        tx_done_o;

  uart_tx_serializer_if fif ();

  uart_tx_serializer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tx_en_i      (tx_en_i),
    .baud_div_i   (baud_div_i),
    .parity_odd_i (parity_odd_i),
    .fifo_if      (fif),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .tx_done_o    (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         pop_cnt  = 0;
  int         frame_id = 0;
  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural FIFO: pops on the strobe, data valid well before the following edge.
  always @(negedge clk_i) begin
    if (fif.fifo_rd_o === 1'b1) begin
      check("pop_only_when_nonempty", fif.fifo_empty_i, 1'b0);
      if (fifo_q.size() > 0) fif.fifo_data_i = fifo_q.pop_front();
      pop_cnt++;
    end
    fif.fifo_empty_i = (fifo_q.size() == 0);
  end

  // Reference frame: start, data LSB first, optional parity, stop; every bit lasts div clocks.
  task automatic check_frame(input exp_t e);
    logic [10:0] bits;
    int          nb;
    int          done_at;
    int          id;
    bit          aborted;
    logic        got_bit;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
`ifdef UART_TX_PARITY_EN
    nb       = 11;
    bits[9]  = logic'(($countones(e.data) % 2) == 1) ^ e.odd;
    bits[10] = 1'b1;
`else
    nb       = 10;
    bits[9]  = 1'b1;
`endif
    id = frame_id;
    frame_id++;
    start_cyc_q.push_back(cyc);
    done_at = -1;
    aborted = 0;
    for (int b = 0; b < nb && !aborted; b++) begin
      got_bit = bits[b];
      for (int c = 0; c < e.div && !aborted; c++) begin
        if (b != 0 || c != 0) @(negedge clk_i);
        if (rst_ni !== 1'b1) begin
          aborted = 1;
        end else begin
          if (tx_o !== bits[b] && got_bit === bits[b]) got_bit = tx_o;
          if (tx_done_o === 1'b1 && done_at < 0) done_at = b * e.div + c;
        end
      end
      if (!aborted) check($sformatf("frame%0d_bit%0d", id, b), got_bit, bits[b]);
    end
    if (!aborted) begin
      check($sformatf("frame%0d_done_offset", id), done_at, nb * e.div - 1);
      done_cyc_q.push_back(cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1 && tx_o === 1'b0) begin
        check("frame_was_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_frame(e);
        end else begin
          while (tx_o === 1'b0) @(negedge clk_i);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input int div_eff, input bit with_exp);
    exp_t e;
    @(posedge clk_i);
    #1;
    e.data = d;
    e.div  = div_eff;
    e.odd  = parity_odd_i;
    fifo_q.push_back(d);
    if (with_exp) exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_drained"}, (exp_q.size() == 0) && (busy_o === 1'b0), 1'b1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (tx_o !== 1'b0 && n < 200);
    check({name, "_start_seen"}, tx_o === 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int p0, s0, d0, gap, div_in, div_eff, nbytes;
    rst_ni       = 1'b0;
    tx_en_i      = 1'b0;
    baud_div_i   = 16'd4;
    parity_odd_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_tx_high", tx_o, 1'b1);
    check("reset_busy_low", busy_o, 1'b0);
    check("reset_no_pop", fif.fifo_rd_o, 1'b0);
    check("reset_no_done", tx_done_o, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tx_en_i = 1'b1;

    // single 0xA5 frame at div 4
    p0 = pop_cnt;
    push(8'hA5, 4, 1);
    wait_drain("t1");
    check("t1_pops", pop_cnt - p0, 1);

    // back-to-back 0x00, 0xFF at div 2
    baud_div_i = 16'd2;
    p0 = pop_cnt;
    s0 = start_cyc_q.size();
    d0 = done_cyc_q.size();
    push(8'h00, 2, 1);
    push(8'hFF, 2, 1);
    wait_drain("t2");
    check("t2_pops", pop_cnt - p0, 2);
    check("t2_done_pulses", done_cyc_q.size() - d0, 2);
    gap = (start_cyc_q.size() >= s0 + 2 && done_cyc_q.size() >= d0 + 1) ?
          start_cyc_q[s0+1] - done_cyc_q[d0] - 1 : -1;
    check("t2_idle_gap", gap, 2);

    // 0x07 at div 3 with even then odd parity selection
    baud_div_i = 16'd3;
    parity_odd_i = 1'b0;
    push(8'h07, 3, 1);
    wait_drain("t3_even");
    parity_odd_i = 1'b1;
    push(8'h07, 3, 1);
    wait_drain("t3_odd");
    parity_odd_i = 1'b0;

    // reset during data bit 3 aborts the frame
    baud_div_i = 16'd4;
    p0 = pop_cnt;
    push(8'hA5, 4, 1);
    wait_start("t4");
    repeat (17) @(negedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("t4_tx_high_after_reset", tx_o, 1'b1);
    check("t4_busy_low_after_reset", busy_o, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    check("t4_single_pop", pop_cnt - p0, 1);
    check("t4_idle", busy_o, 1'b0);

    // tx_en dropped during START with two bytes queued
    baud_div_i = 16'd2;
    p0 = pop_cnt;
    push(8'h3C, 2, 1);
    push(8'hE1, 2, 0);
    wait_start("t5");
    tx_en_i = 1'b0;
    wait_drain("t5_first");
    repeat (10) @(negedge clk_i);
    check("t5_one_pop", pop_cnt - p0, 1);
    check("t5_idle", busy_o, 1'b0);
    check("t5_byte_left", fifo_q.size(), 1);
    exp_q.push_back('{data: 8'hE1, div: 2, odd: parity_odd_i});
    tx_en_i = 1'b1;
    wait_drain("t5_second");
    check("t5_two_pops", pop_cnt - p0, 2);

    // divisor change mid-frame takes effect at the next frame; zero acts as one
    baud_div_i = 16'd4;
    push(8'h5A, 4, 1);
    push(8'hC3, 8, 1);
    wait_start("t6");
    baud_div_i = 16'd8;
    wait_drain("t6_4_then_8");
    baud_div_i = 16'd0;
    push(8'h96, 1, 1);
    wait_drain("t6_div0");

    // randomized batches
    for (int batch = 0; batch < 8; batch++) begin
      div_in       = $urandom_range(0, 6);
      div_eff      = (div_in == 0) ? 1 : div_in;
      baud_div_i   = 16'(div_in);
      parity_odd_i = 1'($urandom_range(0, 1));
      nbytes       = $urandom_range(1, 3);
      p0           = pop_cnt;
      for (int k = 0; k < nbytes; k++) push(8'($urandom), div_eff, 1);
      wait_drain($sformatf("rand%0d", batch));
      check($sformatf("rand%0d_pops", batch), pop_cnt - p0, nbytes);
    end

    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", exp_q.size(), 0);
    check("end_line_idle_high", tx_o, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
